// File: rtl/ram_no_change_arbiter_pkg.sv
// Shared types and helpers for the two-requester no-change RAM arbiter.
// Statistics ports are built only when RAM_ARB_STATS_EN is defined.
package ram_arb_pkg;

   typedef enum logic [1:0] {
      ARB   = 2'd0,
      LOCK0 = 2'd1,
      LOCK1 = 2'd2
   } state_t;

   localparam int STATS_W = 16;

   // Width needed to hold burst counts 0..max_burst inclusive.
   function automatic int burst_w(input int max_burst);
      return $clog2(max_burst + 1);
   endfunction

   function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v,
                                                  input logic en);
      return (en && (v != '1)) ? v + STATS_W'(1) : v;
   endfunction

endpackage

// File: rtl/ram_no_change_arbiter_if.sv
// One requester's port bundle: request channel plus its read-response channel.
// Handshake: a beat transfers on a cycle where valid && ready. valid and the
// request fields must not depend on ready; ready may depend on valid. The
// response channel has no ready: rsp_valid is a single-cycle pulse the client
// must sink.
interface ram_no_change_arbiter_if #(
   parameter int addressWidth = 5,
   parameter int dataWidth    = 32
);
   logic                    valid;
   logic                    ready;
   logic                    we;
   logic                    lock;
   logic [addressWidth-1:0] address;
   logic [dataWidth-1:0]    din;
   logic                    rsp_valid;
   logic [dataWidth-1:0]    rsp_data;

   modport master (
      output valid, we, lock, address, din,
      input  ready, rsp_valid, rsp_data
   );

   modport slave (
      input  valid, we, lock, address, din,
      output ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/ram_no_change_arbiter_rr_pick2.sv
// Two-way round-robin picker: one-hot grant from two valids and the last winner.
module rr_pick2 (
   input  logic       valid0,
   input  logic       valid1,
   input  logic       last_grant,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      if (valid0 && valid1) begin
         grant = last_grant ? 2'b01 : 2'b10;
      end else begin
         grant = {valid1, valid0};
      end
   end

endmodule

// File: rtl/ram_no_change_arbiter.sv
// Shares one single-port no-change RAM between two requesters with round-robin
// arbitration and bounded burst locking. Optional counters: RAM_ARB_STATS_EN.
module ram_no_change_arbiter
   import ram_arb_pkg::*;
#(
   parameter int addressWidth = 5,
   parameter int dataWidth    = 32,
   parameter int MAX_BURST    = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   ram_no_change_arbiter_if.slave  req0,
   ram_no_change_arbiter_if.slave  req1,
   output logic                    ram_en,
   output logic                    ram_we,
   output logic [addressWidth-1:0] ram_address,
   output logic [dataWidth-1:0]    ram_din,
   input  logic [dataWidth-1:0]    ram_dout,
`ifdef RAM_ARB_STATS_EN
   output logic [STATS_W-1:0]      grant_cnt0,
   output logic [STATS_W-1:0]      grant_cnt1,
   output logic [STATS_W-1:0]      force_rel_cnt,
`endif
   output state_t                  dbg_state
);

   localparam int            BW        = burst_w(MAX_BURST);
   localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

   state_t        state, state_nx;
   logic          last_grant, last_grant_nx;
   logic [BW-1:0] burst_cnt, burst_cnt_nx;
   logic [1:0]    pick;
   logic [1:0]    gnt;
   logic          acc;
   logic          acc_id;
   logic          acc_we;
   logic          acc_lock;
   logic          burst_last;
   logic          force_rel;
   logic          rd_pending;
   logic          rd_owner;

   rr_pick2 u_pick (
      .valid0     (req0.valid),
      .valid1     (req1.valid),
      .last_grant (last_grant),
      .grant      (pick)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ARB;
         last_grant <= 1'b1;
         burst_cnt  <= '0;
      end else begin
         state      <= state_nx;
         last_grant <= last_grant_nx;
         burst_cnt  <= burst_cnt_nx;
      end
   end

   assign burst_last = ((burst_cnt + BW'(1)) == BURST_MAX);

   // Next-state logic
   always_comb begin
      state_nx      = state;
      last_grant_nx = last_grant;
      burst_cnt_nx  = burst_cnt;
      force_rel     = 1'b0;
      case (state)
         ARB: begin
            if (acc) begin
               last_grant_nx = acc_id;
               if (acc_lock && (MAX_BURST > 1)) begin
                  state_nx     = acc_id ? LOCK1 : LOCK0;
                  burst_cnt_nx = BW'(1);
               end else begin
                  // A one-beat limit turns every locked request into a release.
                  force_rel = acc_lock;
               end
            end
         end
         LOCK0, LOCK1: begin
            if (acc) begin
               if (!acc_lock || burst_last) begin
                  state_nx      = ARB;
                  last_grant_nx = acc_id;
                  burst_cnt_nx  = '0;
                  force_rel     = acc_lock;
               end else begin
                  burst_cnt_nx = burst_cnt + BW'(1);
               end
            end
         end
         default: begin
            state_nx     = ARB;
            burst_cnt_nx = '0;
         end
      endcase
   end

   // Output logic: grant, ready and RAM drive; everything is quiet in reset
   always_comb begin
      gnt = 2'b00;
      if (rst_n) begin
         case (state)
            ARB:     gnt = pick;
            LOCK0:   gnt = {1'b0, req0.valid};
            LOCK1:   gnt = {req1.valid, 1'b0};
            default: gnt = 2'b00;
         endcase
      end
      acc         = |gnt;
      acc_id      = gnt[1];
      acc_we      = gnt[1] ? req1.we   : req0.we;
      acc_lock    = gnt[1] ? req1.lock : req0.lock;
      req0.ready  = gnt[0];
      req1.ready  = gnt[1];
      ram_en      = acc;
      ram_we      = acc & acc_we;
      ram_address = '0;
      ram_din     = '0;
      if (gnt[1]) begin
         ram_address = req1.address;
         ram_din     = req1.din;
      end else if (gnt[0]) begin
         ram_address = req0.address;
         ram_din     = req0.din;
      end
      dbg_state = state;
   end

   // Read-response tracking: ram_dout is only meaningful the cycle after a read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_pending <= 1'b0;
         rd_owner   <= 1'b0;
      end else begin
         rd_pending <= acc & ~acc_we;
         rd_owner   <= acc_id;
      end
   end

   always_comb begin
      req0.rsp_valid = rd_pending & ~rd_owner;
      req1.rsp_valid = rd_pending &  rd_owner;
      req0.rsp_data  = req0.rsp_valid ? ram_dout : '0;
      req1.rsp_data  = req1.rsp_valid ? ram_dout : '0;
   end

`ifdef RAM_ARB_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_cnt0    <= '0;
         grant_cnt1    <= '0;
         force_rel_cnt <= '0;
      end else begin
         grant_cnt0    <= sat_inc(grant_cnt0, gnt[0]);
         grant_cnt1    <= sat_inc(grant_cnt1, gnt[1]);
         force_rel_cnt <= sat_inc(force_rel_cnt, force_rel);
      end
   end
`endif

endmodule

// File: tb/tb_ram_no_change_arbiter.sv
// Bench for ram_no_change_arbiter: vector table, hand sequences for lock and
// reset corners, then random traffic checked against a transaction-level model.
module tb_ram_no_change_arbiter;
   import ram_arb_pkg::*;

   localparam int AW = 5;
   localparam int DW = 32;
   localparam int MB = 4;

   typedef struct packed {
      logic          valid;
      logic          we;
      logic          lock;
      logic [AW-1:0] addr;
      logic [DW-1:0] din;
   } beat_t;

   typedef struct {
      beat_t         b0;
      beat_t         b1;
      logic          r0;
      logic          r1;
      logic          rv0;
      logic          rv1;
      logic [DW-1:0] rdata;
   } vec_t;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   ram_no_change_arbiter_if #(.addressWidth(AW), .dataWidth(DW)) req0_if ();
   ram_no_change_arbiter_if #(.addressWidth(AW), .dataWidth(DW)) req1_if ();

   logic          ram_en;
   logic          ram_we;
   logic [AW-1:0] ram_address;
   logic [DW-1:0] ram_din;
   logic [DW-1:0] ram_dout = '0;
   state_t        dbg_state;
`ifdef RAM_ARB_STATS_EN
   logic [STATS_W-1:0] grant_cnt0, grant_cnt1, force_rel_cnt;
`endif

   ram_no_change_arbiter #(
      .addressWidth (AW),
      .dataWidth    (DW),
      .MAX_BURST    (MB)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req0        (req0_if),
      .req1        (req1_if),
      .ram_en      (ram_en),
      .ram_we      (ram_we),
      .ram_address (ram_address),
      .ram_din     (ram_din),
      .ram_dout    (ram_dout),
`ifdef RAM_ARB_STATS_EN
      .grant_cnt0    (grant_cnt0),
      .grant_cnt1    (grant_cnt1),
      .force_rel_cnt (force_rel_cnt),
`endif
      .dbg_state   (dbg_state)
   );

   // No-change single-port RAM: dout only updates on read beats.
   logic [DW-1:0] ram_mem [32] = '{default: '0};
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) ram_mem[ram_address] <= ram_din;
         else        ram_dout <= ram_mem[ram_address];
      end
   end

   // ---------------- scoreboard / model state ----------------
   int            n_checks = 0;
   int            n_fail   = 0;
   int            lock_to  = -1;   // requester holding the lock, -1 = none
   int            beats    = 0;    // beats taken in the current lock
   int            prio     = 0;    // requester that wins a tie
   logic [DW-1:0] shadow [32] = '{default: '0};
   logic [DW:0]   exp_q[$];        // {owner, data} due next cycle

   logic          r0, r1, rv0, rv1;
   logic [DW-1:0] d0, d1;
   vec_t          tbl [10];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic beat_t idle_b();
      return '0;
   endfunction

   function automatic beat_t rd_b(input logic [AW-1:0] a, input logic lk);
      beat_t b = '0;
      b.valid = 1'b1;
      b.lock  = lk;
      b.addr  = a;
      return b;
   endfunction

   function automatic beat_t wr_b(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic lk);
      beat_t b = '0;
      b.valid = 1'b1;
      b.we    = 1'b1;
      b.lock  = lk;
      b.addr  = a;
      b.din   = d;
      return b;
   endfunction

   function automatic beat_t rnd_b();
      beat_t b;
      b.valid = ($urandom_range(0, 3) != 0);
      b.we    = 1'($urandom_range(0, 1));
      b.lock  = ($urandom_range(0, 2) != 0);
      b.addr  = AW'($urandom_range(0, 7));
      b.din   = $urandom;
      return b;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic apply(input beat_t b0, input beat_t b1);
      req0_if.valid   = b0.valid;
      req0_if.we      = b0.we;
      req0_if.lock    = b0.lock;
      req0_if.address = b0.addr;
      req0_if.din     = b0.din;
      req1_if.valid   = b1.valid;
      req1_if.we      = b1.we;
      req1_if.lock    = b1.lock;
      req1_if.address = b1.addr;
      req1_if.din     = b1.din;
   endtask

   task automatic model_reset();
      lock_to = -1;
      beats   = 0;
      prio    = 0;
      exp_q.delete();
   endtask

   // Enter reset with requests pending, check everything is silent, release.
   task automatic do_reset();
      apply(rd_b(AW'(0), 1'b1), wr_b(AW'(1), 32'hFFFF_FFFF, 1'b1));
      rst_n = 1'b0;
      #3;
      check("rst_ready0", req0_if.ready, 0);
      check("rst_ready1", req1_if.ready, 0);
      check("rst_ram_en", ram_en, 0);
      check("rst_ram_we", ram_we, 0);
      check("rst_ram_address", ram_address, 0);
      check("rst_ram_din", ram_din, 0);
      check("rst_rsp0_valid", req0_if.rsp_valid, 0);
      check("rst_rsp1_valid", req1_if.rsp_valid, 0);
      check("rst_rsp0_data", req0_if.rsp_data, 0);
      check("rst_rsp1_data", req1_if.rsp_data, 0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // One clock: drive, sample mid-cycle, check against the model, advance.
   task automatic step(input beat_t b0, input beat_t b1,
                       output logic o_r0, output logic o_r1,
                       output logic o_rv0, output logic o_rv1,
                       output logic [DW-1:0] o_d0, output logic [DW-1:0] o_d1);
      beat_t       bb [2];
      int          w;
      logic [DW:0] e;
      bb[0] = b0;
      bb[1] = b1;
      apply(b0, b1);
      #3;
      o_r0  = req0_if.ready;
      o_r1  = req1_if.ready;
      o_rv0 = req0_if.rsp_valid;
      o_rv1 = req1_if.rsp_valid;
      o_d0  = req0_if.rsp_data;
      o_d1  = req1_if.rsp_data;

      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("rsp0_valid", o_rv0, !e[DW]);
         check("rsp1_valid", o_rv1, e[DW]);
         check("rsp0_data", o_d0, e[DW] ? '0 : e[DW-1:0]);
         check("rsp1_data", o_d1, e[DW] ? e[DW-1:0] : '0);
      end else begin
         check("rsp0_idle", o_rv0, 0);
         check("rsp1_idle", o_rv1, 0);
      end

      w = -1;
      if (lock_to >= 0) begin
         if (bb[lock_to].valid) w = lock_to;
      end else if (b0.valid && b1.valid) begin
         w = prio;
      end else if (b0.valid) begin
         w = 0;
      end else if (b1.valid) begin
         w = 1;
      end

      check("ready0", o_r0, (w == 0));
      check("ready1", o_r1, (w == 1));
      check("ram_en", ram_en, (w >= 0));
      if (w >= 0) begin
         check("ram_we", ram_we, bb[w].we);
         check("ram_address", ram_address, bb[w].addr);
         check("ram_din", ram_din, bb[w].din);
         if (bb[w].we) shadow[bb[w].addr] = bb[w].din;
         else          exp_q.push_back({(w == 1), shadow[bb[w].addr]});
         if (lock_to < 0) begin
            prio = 1 - w;
            if (bb[w].lock && (MB > 1)) begin
               lock_to = w;
               beats   = 1;
            end
         end else begin
            beats++;
            if (!bb[w].lock || (beats == MB)) begin
               lock_to = -1;
               prio    = 1 - w;
            end
         end
      end else begin
         check("ram_we_idle", ram_we, 0);
         check("ram_address_idle", ram_address, 0);
         check("ram_din_idle", ram_din, 0);
      end
      @(posedge clk);
      #1;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      tbl[0] = '{idle_b(), idle_b(), 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
      tbl[1] = '{idle_b(), idle_b(), 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
      tbl[2] = '{wr_b(AW'(0), 32'h1, 1'b0), idle_b(), 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
      tbl[3] = '{rd_b(AW'(0), 1'b0), idle_b(), 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
      tbl[4] = '{idle_b(), wr_b(AW'(1), 32'h22, 1'b0), 1'b0, 1'b1, 1'b1, 1'b0, 32'h1};
      tbl[5] = '{rd_b(AW'(1), 1'b0), rd_b(AW'(0), 1'b0), 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
      tbl[6] = '{rd_b(AW'(1), 1'b0), rd_b(AW'(0), 1'b0), 1'b0, 1'b1, 1'b1, 1'b0, 32'h22};
      tbl[7] = '{rd_b(AW'(1), 1'b0), rd_b(AW'(0), 1'b0), 1'b1, 1'b0, 1'b0, 1'b1, 32'h1};
      tbl[8] = '{idle_b(), idle_b(), 1'b0, 1'b0, 1'b1, 1'b0, 32'h22};
      tbl[9] = '{idle_b(), idle_b(), 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};

      #1;
      do_reset();

      for (int i = 0; i < 10; i++) begin
         step(tbl[i].b0, tbl[i].b1, r0, r1, rv0, rv1, d0, d1);
         check("tbl_ready0", r0, tbl[i].r0);
         check("tbl_ready1", r1, tbl[i].r1);
         check("tbl_rsp0_valid", rv0, tbl[i].rv0);
         check("tbl_rsp1_valid", rv1, tbl[i].rv1);
         if (tbl[i].rv0) check("tbl_rsp0_data", d0, tbl[i].rdata);
         if (tbl[i].rv1) check("tbl_rsp1_data", d1, tbl[i].rdata);
      end

      // Burst lock: four locked req0 beats, then forced hand-over to req1.
      do_reset();
      for (int k = 0; k < 5; k++) begin
         step(wr_b(AW'(k + 4), DW'(32'hA0 + k), 1'b1), rd_b(AW'(1), 1'b0), r0, r1, rv0, rv1, d0, d1);
         check("burst_ready0", r0, (k < 4));
         check("burst_ready1", r1, (k == 4));
      end

      // Lock held across idle cycles of the owner.
      step(wr_b(AW'(8), 32'h55, 1'b1), rd_b(AW'(2), 1'b0), r0, r1, rv0, rv1, d0, d1);
      check("hold_ready0_first", r0, 1);
      for (int k = 0; k < 2; k++) begin
         step(idle_b(), rd_b(AW'(2), 1'b0), r0, r1, rv0, rv1, d0, d1);
         check("hold_ready1_blocked", r1, 0);
      end
      step(wr_b(AW'(9), 32'h66, 1'b0), rd_b(AW'(2), 1'b0), r0, r1, rv0, rv1, d0, d1);
      check("hold_ready0_unlock", r0, 1);
      step(rd_b(AW'(8), 1'b0), rd_b(AW'(2), 1'b0), r0, r1, rv0, rv1, d0, d1);
      check("hold_ready1_after", r1, 1);
      step(idle_b(), idle_b(), r0, r1, rv0, rv1, d0, d1);

      // Reset in the cycle after a read accept drops the response.
      step(rd_b(AW'(8), 1'b0), idle_b(), r0, r1, rv0, rv1, d0, d1);
      check("mid_ready0", r0, 1);
      apply(rd_b(AW'(8), 1'b0), rd_b(AW'(9), 1'b0));
      rst_n = 1'b0;
      #3;
      check("mid_rsp0_valid", req0_if.rsp_valid, 0);
      check("mid_rsp0_data", req0_if.rsp_data, 0);
      check("mid_ready0_rst", req0_if.ready, 0);
      check("mid_ram_en_rst", ram_en, 0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(rd_b(AW'(9), 1'b0), rd_b(AW'(8), 1'b0), r0, r1, rv0, rv1, d0, d1);
      check("mid_first_ready0", r0, 1);
      check("mid_no_rsp0", rv0, 0);
      step(idle_b(), idle_b(), r0, r1, rv0, rv1, d0, d1);
      check("mid_rsp0_after", rv0, 1);
      check("mid_rsp0_data_after", d0, 32'h66);

      // Random traffic against the model.
      for (int k = 0; k < 400; k++) begin
         step(rnd_b(), rnd_b(), r0, r1, rv0, rv1, d0, d1);
      end
      step(idle_b(), idle_b(), r0, r1, rv0, rv1, d0, d1);
      step(idle_b(), idle_b(), r0, r1, rv0, rv1, d0, d1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ram_no_change_arbiter.md
Name: ram_no_change_arbiter

Overview:
- Shares one single-port, no-change-mode synchronous RAM (en/we/address/din/dout, 1-cycle read latency) between two requesters.
- Round-robin arbitration, with a bounded burst lock so a requester can hold the RAM for back-to-back beats.
- Issues one RAM access per cycle and returns read data to the owner exactly one cycle after acceptance.
- Sits between client logic and the RAM instance; drives the RAM's ports directly.

Parameters:
- addressWidth, 5, RAM address width.
- dataWidth, 32, RAM data width.
- MAX_BURST, 4, maximum consecutive locked beats per grant (>=1).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- reqN_valid  in  1  request present (N = 0,1, same set per requester)
- reqN_ready  out  1  request accepted this cycle
- reqN_we  in  1  1 = write, 0 = read
- reqN_lock  in  1  keep grant for the next beat
- reqN_address  in  addressWidth  target address
- reqN_din  in  dataWidth  write data
- rspN_valid  out  1  read data valid pulse
- rspN_data  out  dataWidth  read data
- ram_en  out  1  RAM enable
- ram_we  out  1  RAM write enable
- ram_address  out  addressWidth  RAM address
- ram_din  out  dataWidth  RAM write data
- ram_dout  in  dataWidth  RAM read data, valid 1 cycle after a read beat

Behaviour:
- Reset (rst_n low, async):
  - State = ARB; last_grant = 1 (so requester 0 wins first); burst_cnt = 0; rd_pending = 0.
  - All outputs 0 while rst_n is low, including reqN_ready and ram_en.
- Accept: beat accepted when reqN_valid && reqN_ready. At most one ready high per cycle.
- Grant and RAM drive: grant is combinational from state, valids and last_grant.
  - Granted request drives ram_en=1 and ram_we/address/din in the same cycle; RAM samples at that edge.
  - No grant: ram_en=0, ram_we=0, other RAM outputs 0.
- FSM states ARB, LOCK0, LOCK1:
  - ARB, one valid: grant it.
  - ARB, both valid: grant !last_grant.
  - On accept in ARB: last_grant <= N. If reqN_lock=1 and MAX_BURST>1, go to LOCKN with burst_cnt=1; else stay in ARB.
  - LOCKN: only requester N may be granted; the other's ready is 0 even if N is idle. Idle cycles keep the lock.
  - On accept in LOCKN: burst_cnt++.
    - If reqN_lock=0, or burst_cnt+1 == MAX_BURST, return to ARB with last_grant=N, so the other requester has priority next.
    - Otherwise stay in LOCKN.
- Read response:
  - On a read accept, register rd_pending=1 and rd_owner=N.
  - Next cycle, rsp{rd_owner}_valid=1 and rsp{rd_owner}_data=ram_dout; the other rsp_data is 0.
  - Write accepts produce no response.
  - Latency is exactly 1 cycle and there is no backpressure; clients must sink responses.
- No-change semantics: ram_dout is ignored except in the cycle after a read beat. Write beats leave the previous response untouched and generate no pulse.
- Back-to-back reads from alternating requesters give one rsp pulse per cycle to the correct owner.
- Reset mid-operation: lock and any pending response are dropped; rspN_valid goes 0 immediately.

Optional Feature:
- RAM_ARB_STATS_EN defined:
  - Adds output ports grant_cnt0 and grant_cnt1, each 16 bits, counting accepted beats per requester.
  - Adds output port force_rel_cnt, 16 bits, counting releases forced by MAX_BURST.
  - All three saturate at 0xFFFF and reset to 0.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package ram_arb_pkg holds:
  - state enum {ARB, LOCK0, LOCK1};
  - STATS_W = 16;
  - burst counter width $clog2(MAX_BURST+1), as a localparam function.
- One natural sub-module, rr_pick2: two valids plus last_grant in, one-hot grant out, combinational. Instantiated once.

Test Plan:
- Reset then idle: all outputs 0, ram_en=0 throughout.
- Write/read round trip: req0 writes 0x1 to addr 0, then reads addr 0 → rsp0_valid pulses one cycle after the read accept with rsp0_data=0x1; rsp1_valid stays 0.
- Contention: both valid every cycle, unlocked reads → grants alternate 0,1,0,1; each rsp pulses on the matching owner one cycle later.
- Burst lock, MAX_BURST=4: req0 holds lock=1 with both valid → four consecutive req0 beats, then forced release; req1 is granted next.
- Lock hold with idle: req0 locks, then drops valid for 2 cycles while req1 is valid → req1_ready=0 in those cycles; req0 resumes with lock=0 → ARB entered, req1 granted next.
- Reset mid-read: assert rst_n low in the cycle after a read accept → rsp valid never asserts; after release, req0 is granted first.
